load_store_unit: RTL
====================

# load_store_unit

Parametrised data-memory access unit that sits between the core's execute stage and the shared memory bus (sel/addr/we/wr_mask/data/ack). It takes one load or store request at a time and aligns addresses to the bus word. It generates byte-lane masks, sign- or zero-extends load data, and splits accesses that straddle a bus word into two bus beats. When splitting is disabled, a misaligned access returns a fault instead.

## Interface
- DATA_W, 32: bus and register data width; 32 or 64. BYTES = DATA_W/8.
- ADDR_W, 32: byte address width.
- ALLOW_MISALIGNED, 1: 1 = split straddling accesses into two beats; 0 = any access whose address is not a multiple of its size faults.
- clk  in  1  clock; all logic on rising edge.
- reset_ni  in  1  reset: one clock, synchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit idle, request accepted when valid & ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_size_i  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- req_sext_i  in  1  sign-extend load result.
- req_wdata_i  in  DATA_W  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  DATA_W  extended load data; 0 for stores and faults.
- rsp_fault_o  out  1  valid with rsp_valid_o; illegal size or disallowed misalignment.
- sel_o  out  1  bus strobe, held until ack.
- addr_o  out  ADDR_W  bus address, low log2(BYTES) bits always 0.
- we_o  out  1  bus write enable.
- wr_mask_o  out  BYTES  byte-lane mask.
- data_out_o  out  DATA_W  bus write data.
- data_in_i  in  DATA_W  bus read data, valid with ack_i.
- ack_i  in  1  bus acknowledge; ignored while sel_o = 0.

## Operation
- States: IDLE, BUS1, GAP, BUS2, RESP.
- IDLE: req_ready_o = 1. On accept, latch the request and compute the following:
  - off = addr mod BYTES; nb = 1 << size.
  - 2*BYTES-bit mask M = ((1<<nb)-1) << off.
  - 2*DATA_W-bit store word W = wdata << 8*off.
- IDLE transitions on accept:
  - Fault if size = 3 with DATA_W = 32, or if ALLOW_MISALIGNED = 0 and addr mod nb ≠ 0: go to RESP with fault = 1 and no bus cycle.
  - Otherwise go to BUS1.
- BUS1:
  - sel_o = 1, addr_o = addr with low bits cleared, we_o = req_we.
  - wr_mask_o = M[BYTES-1:0] (loads drive the same mask); data_out_o = W[DATA_W-1:0].
  - On ack_i, capture data_in_i into lo.
  - If M[2*BYTES-1:BYTES] ≠ 0, go to GAP; else hi = 0 and go to RESP.
- GAP: sel_o = 0 and we_o = 0 for exactly one cycle, then BUS2.
- BUS2:
  - sel_o = 1, addr_o = BUS1 address + BYTES (wraps modulo 2^ADDR_W).
  - wr_mask_o = M[2*BYTES-1:BYTES]; data_out_o = W[2*DATA_W-1:DATA_W].
  - On ack_i, capture data_in_i into hi and go to RESP.
- RESP:
  - rsp_valid_o = 1.
  - Load: rsp_rdata_o = ({hi,lo} >> 8*off) truncated to nb bytes, then sign- or zero-extended per sext to DATA_W.
  - Store and fault: rsp_rdata_o = 0.
  - Next state: IDLE.
- A word-aligned word access never splits. A byte access never splits.

## Timing
- Reset (reset_ni = 0 at an edge) forces the following values at that edge, regardless of state:
  - State goes to IDLE.
  - sel_o, we_o, rsp_valid_o, rsp_fault_o go to 0.
  - wr_mask_o, addr_o, data_out_o, rsp_rdata_o go to 0.
  - req_ready_o is 1 from the first cycle after reset is released.
- Reset mid-transaction: the bus cycle is abandoned (sel_o low at that edge) and no response is produced.
- Accept at edge 0. sel_o is high in cycle 1 and stays high while ack_i = 0.
- ack_i sampled high at edge k: sel_o and we_o are low from edge k.
- Single beat:
  - rsp_valid_o is high in cycle k+1.
  - req_ready_o is high again from cycle k+2.
  - Minimum accept-to-accept is 3 cycles.
- Split: BUS2 sel_o rises at edge k+1 (GAP occupies cycle k+1, strobe high from k+2); the response follows the BUS2 ack as above.
- Fault: rsp_valid_o is high in cycle 1 and sel_o is never asserted.
- Bus outputs are registered. addr_o, wr_mask_o and data_out_o are stable for the whole time sel_o is high.
- req_* inputs are ignored when req_ready_o = 0.

## Test plan
- DATA_W = 32, LW 0x100, slave acks 2 cycles after sel with 0xDEADBEEF:
  - Bus: one beat, addr_o = 0x100, wr_mask_o = 1111.
  - Response: rsp_rdata_o = 0xDEADBEEF, rsp_valid_o 1 cycle after ack.
- LB at 0x103, bus data 0x80123456:
  - sext = 1 → 0xFFFFFF80.
  - sext = 0 → 0x00000080.
  - Single beat, addr_o = 0x100.
- SH at 0x102 with wdata 0x1234ABCD → addr_o = 0x100, wr_mask_o = 1100, data_out_o = 0xABCD0000, we_o = 1, rsp_rdata_o = 0.
- ALLOW_MISALIGNED = 1:
  - SW 0x103, wdata 0x11223344 → beat1: 0x100, mask 1000, data 0x44000000. One idle GAP cycle. Beat2: 0x104, mask 0111, data 0x00112233.
  - LW 0x103 with beats 0xAABBCCDD then 0x00112233 → 0x112233AA.
- ALLOW_MISALIGNED = 0, LW 0x102 → sel_o never high, rsp_valid_o and rsp_fault_o high in cycle 1, rsp_rdata_o = 0. Also size = 3 with DATA_W = 32 faults.
- Reset and wrap:
  - reset_ni low for one edge while BUS2 sel_o is high → sel_o = 0 after that edge, no rsp_valid_o, req_ready_o = 1 after release.
  - DATA_W = 64, LD at 0xFFFFFFFC → beat2 addr_o = 0x00000000.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and the shared memory bus.
// Aligns accesses to bus words, builds byte-lane masks, extends load data and splits straddling accesses into two beats.
module load_store_unit #(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 32,
   parameter int ALLOW_MISALIGNED = 1
) (
   input  logic                  clk,
   input  logic                  reset_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_sext_i,
   input  logic [DATA_W-1:0]     req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic                  rsp_fault_o,
   output logic                  sel_o,
   output logic [ADDR_W-1:0]     addr_o,
   output logic                  we_o,
   output logic [DATA_W/8-1:0]   wr_mask_o,
   output logic [DATA_W-1:0]     data_out_o,
   input  logic [DATA_W-1:0]     data_in_i,
   input  logic                  ack_i
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_BUS1 = 3'd1;
   localparam logic [2:0] S_GAP  = 3'd2;
   localparam logic [2:0] S_BUS2 = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]            state;
   logic [OFF_W-1:0]      off_q;
   logic [1:0]            size_q;
   logic                  sext_q;
   logic                  we_q;
   logic [2*BYTES-1:0]    mask_q;
   logic [2*DATA_W-1:0]   wword_q;
   logic [DATA_W-1:0]     lo_q;

   logic [OFF_W-1:0]      req_off;
   logic [3:0]            nb;
   logic [2*BYTES-1:0]    base_mask;
   logic [2*BYTES-1:0]    acc_mask;
   logic [2*DATA_W-1:0]   acc_word;
   logic                  misaligned;
   logic                  acc_fault;

   assign req_ready_o = (state == S_IDLE);

   // Lane mask, shifted store word and fault decision for the request being offered.
   always_comb begin
      req_off   = req_addr_i[OFF_W-1:0];
      nb        = 4'd1 << req_size_i;
      base_mask = '0;
      for (int i = 0; i < 2*BYTES; i++) begin
         base_mask[i] = (i < int'(nb));
      end
      acc_mask   = base_mask << req_off;
      acc_word   = {{DATA_W{1'b0}}, req_wdata_i} << {req_off, 3'b000};
      misaligned = |({1'b0, req_addr_i[2:0]} & (nb - 4'd1));
      acc_fault  = ((req_size_i == 2'd3) && (DATA_W < 64)) ||
                   ((ALLOW_MISALIGNED == 0) && misaligned);
   end

   logic [DATA_W-1:0] hi_src;
   logic [DATA_W-1:0] lo_src;
   logic [DATA_W-1:0] joined;
   logic              sign_bit;
   int                nbits;
   logic [DATA_W-1:0] load_result;

   // The final beat's data is used straight off the bus so the response can be registered at the ack edge.
   always_comb begin
      hi_src   = (state == S_BUS2) ? data_in_i : '0;
      lo_src   = (state == S_BUS2) ? lo_q : data_in_i;
      joined   = DATA_W'({hi_src, lo_src} >> {off_q, 3'b000});
      nbits    = 8 << size_q;
      case (size_q)
         2'd0:    sign_bit = joined[7];
         2'd1:    sign_bit = joined[15];
         2'd2:    sign_bit = joined[31];
         default: sign_bit = joined[DATA_W-1];
      endcase
      load_result = '0;
      for (int i = 0; i < DATA_W; i++) begin
         load_result[i] = (i < nbits) ? joined[i] : (sext_q & sign_bit);
      end
      if (we_q) begin
         load_result = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         state       <= S_IDLE;
         sel_o       <= 1'b0;
         we_o        <= 1'b0;
         addr_o      <= '0;
         wr_mask_o   <= '0;
         data_out_o  <= '0;
         rsp_valid_o <= 1'b0;
         rsp_fault_o <= 1'b0;
         rsp_rdata_o <= '0;
         off_q       <= '0;
         size_q      <= '0;
         sext_q      <= 1'b0;
         we_q        <= 1'b0;
         mask_q      <= '0;
         wword_q     <= '0;
         lo_q        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  off_q   <= req_off;
                  size_q  <= req_size_i;
                  sext_q  <= req_sext_i;
                  we_q    <= req_we_i;
                  mask_q  <= acc_mask;
                  wword_q <= acc_word;
                  if (acc_fault) begin
                     state       <= S_RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_fault_o <= 1'b1;
                     rsp_rdata_o <= '0;
                  end else begin
                     state      <= S_BUS1;
                     sel_o      <= 1'b1;
                     we_o       <= req_we_i;
                     addr_o     <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     wr_mask_o  <= acc_mask[BYTES-1:0];
                     data_out_o <= acc_word[DATA_W-1:0];
                  end
               end
            end
            S_BUS1: begin
               if (sel_o && ack_i) begin
                  sel_o <= 1'b0;
                  we_o  <= 1'b0;
                  lo_q  <= data_in_i;
                  if (|mask_q[2*BYTES-1:BYTES]) begin
                     state <= S_GAP;
                  end else begin
                     state       <= S_RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_rdata_o <= load_result;
                  end
               end
            end
            S_GAP: begin
               state      <= S_BUS2;
               sel_o      <= 1'b1;
               we_o       <= we_q;
               addr_o     <= addr_o + ADDR_W'(BYTES);
               wr_mask_o  <= mask_q[2*BYTES-1:BYTES];
               data_out_o <= wword_q[2*DATA_W-1:DATA_W];
            end
            S_BUS2: begin
               if (sel_o && ack_i) begin
                  sel_o       <= 1'b0;
                  we_o        <= 1'b0;
                  state       <= S_RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_rdata_o <= load_result;
               end
            end
            S_RESP: begin
               state       <= S_IDLE;
               rsp_valid_o <= 1'b0;
               rsp_fault_o <= 1'b0;
               rsp_rdata_o <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
